// File: rtl/window_buffer_param_if.sv
// -----------------------------------------------------------------------------
// window_buffer_param_if
// Pixel stream between the pixel-fetch controller and the window buffer.
//   pix_valid : producer has a pixel on pix_data
//   pix_data  : pixel value, PIXEL_W bits
//   pix_ready : window buffer accepts a pixel this cycle
// A pixel transfers on a rising edge where pix_valid and pix_ready are both 1.
// -----------------------------------------------------------------------------
interface window_buffer_param_if #(
  parameter int PIXEL_W = 8
) ();

  logic               pix_valid;
  logic [PIXEL_W-1:0] pix_data;
  logic               pix_ready;

  // Producer side (pixel-fetch controller)
  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  // Consumer side (window buffer)
  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );

endinterface

// File: rtl/window_buffer_param.sv
// -----------------------------------------------------------------------------
// window_buffer_param
// WIN x WIN pixel window feeding the gradient compute stage. A full load
// streams WIN*WIN pixels in raster order; a shift moves the whole window one
// step (left/right/up/down) in a single cycle, zeroes the vacated line and then
// refills just that line with WIN streamed pixels.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start_load    : request a full raster-order load (sampled in IDLE only)
//   start_shift   : request a one-step shift plus line fill (IDLE only)
//   shift_direc   : 00 left, 01 right, 10 up, 11 down
//   pix_if        : pixel stream (valid/data in, ready out)
//   busy          : load or fill in progress
//   load_done     : one-cycle pulse after the last load pixel
//   shift_done    : one-cycle pulse after the last fill pixel
//   err_cmd       : one-cycle pulse for an illegal or ignored command
//   win_valid     : window holds a complete, coherent patch
//   window        : element (r,c) at bits [(r*WIN+c)*PIXEL_W +: PIXEL_W]
// -----------------------------------------------------------------------------
module window_buffer_param #(
  parameter int PIXEL_W = 8,
  parameter int WIN     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_load,
  input  logic                       start_shift,
  input  logic [1:0]                 shift_direc,
  window_buffer_param_if.slave       pix_if,
  output logic                       busy,
  output logic                       load_done,
  output logic                       shift_done,
  output logic                       err_cmd,
  output logic                       win_valid,
  output logic [WIN*WIN*PIXEL_W-1:0] window
);

  // The window must have a centre pixel, so only odd sizes of 3 or more work.
  generate
    if ((WIN < 32'sd3) || ((WIN % 32'sd2) == 32'sd0)) begin : g_win_check
      $fatal(1, "window_buffer_param: WIN must be odd and >= 3");
    end
  endgenerate

  localparam int                N_PIX     = WIN * WIN;
  localparam int                CNT_W     = $clog2(N_PIX);
  localparam logic [CNT_W-1:0]  LAST_LOAD = CNT_W'(N_PIX - 32'sd1);
  localparam logic [CNT_W-1:0]  LAST_FILL = CNT_W'(WIN - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'sd1);

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         dir_r;
  logic               loaded_r, loaded_next_s;
  logic               pix_ready_r, busy_r, load_done_r, shift_done_r;
  logic               err_cmd_r, win_valid_r;
  logic               hs_s, last_s, load_go_s, shift_go_s, err_s, busy_next_s;
  logic [PIXEL_W-1:0] win_r      [WIN][WIN];
  logic [PIXEL_W-1:0] shifted_s  [WIN][WIN];
  logic [PIXEL_W-1:0] win_next_s [WIN][WIN];

  // Command decode and state transitions.
  always_comb begin
    state_next_s = state_r;
    load_go_s    = 1'b0;
    shift_go_s   = 1'b0;
    err_s        = 1'b0;
    last_s       = 1'b0;
    hs_s         = pix_if.pix_valid & pix_ready_r;
    case (state_r)
      ST_IDLE: begin
        if (start_load) begin
          // Load takes priority; a simultaneous shift request is flagged.
          state_next_s = ST_LOAD;
          load_go_s    = 1'b1;
          err_s        = start_shift;
        end else if (start_shift) begin
          if (loaded_r) begin
            state_next_s = ST_FILL;
            shift_go_s   = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        err_s = start_load | start_shift;
        if (hs_s && (cnt_r == LAST_LOAD)) begin
          state_next_s = ST_IDLE;
          last_s       = 1'b1;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_FILL: begin
        err_s = start_load | start_shift;
        if (hs_s && (cnt_r == LAST_FILL)) begin
          state_next_s = ST_IDLE;
          last_s       = 1'b1;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next value of the loaded flag and of busy, used for the registered outputs.
  always_comb begin
    busy_next_s = (state_next_s != ST_IDLE);
    if (load_go_s) begin
      loaded_next_s = 1'b0;
    end else if (last_s && (state_r == ST_LOAD)) begin
      loaded_next_s = 1'b1;
    end else begin
      loaded_next_s = loaded_r;
    end
  end

  // One-step shifted copy of the window; the vacated line stays zero.
  always_comb begin
    for (int r = 32'sd0; r < WIN; r++) begin
      for (int c = 32'sd0; c < WIN; c++) begin
        shifted_s[r][c] = '0;
      end
    end
    case (shift_direc)
      DIR_LEFT: begin
        for (int r = 32'sd0; r < WIN; r++) begin
          for (int c = 32'sd0; c < WIN - 32'sd1; c++) begin
            shifted_s[r][c] = win_r[r][c+32'sd1];
          end
        end
      end
      DIR_RIGHT: begin
        for (int r = 32'sd0; r < WIN; r++) begin
          for (int c = 32'sd1; c < WIN; c++) begin
            shifted_s[r][c] = win_r[r][c-32'sd1];
          end
        end
      end
      DIR_UP: begin
        for (int r = 32'sd0; r < WIN - 32'sd1; r++) begin
          for (int c = 32'sd0; c < WIN; c++) begin
            shifted_s[r][c] = win_r[r+32'sd1][c];
          end
        end
      end
      DIR_DOWN: begin
        for (int r = 32'sd1; r < WIN; r++) begin
          for (int c = 32'sd0; c < WIN; c++) begin
            shifted_s[r][c] = win_r[r-32'sd1][c];
          end
        end
      end
      default: begin
        shifted_s[0][0] = '0;
      end
    endcase
  end

  // Next window contents: whole-window shift, or a single pixel write.
  always_comb begin
    logic wr_hit;
    wr_hit     = 1'b0;
    win_next_s = win_r;
    if (shift_go_s) begin
      win_next_s = shifted_s;
    end else if (hs_s) begin
      for (int r = 32'sd0; r < WIN; r++) begin
        for (int c = 32'sd0; c < WIN; c++) begin
          if (state_r == ST_LOAD) begin
            wr_hit = (cnt_r == CNT_W'(r * WIN + c));
          end else begin
            // Fill walks the vacated line: columns top-down, rows left-right.
            case (dir_r)
              DIR_LEFT:  wr_hit = (c == WIN - 32'sd1) && (cnt_r == CNT_W'(r));
              DIR_RIGHT: wr_hit = (c == 32'sd0)       && (cnt_r == CNT_W'(r));
              DIR_UP:    wr_hit = (r == WIN - 32'sd1) && (cnt_r == CNT_W'(c));
              DIR_DOWN:  wr_hit = (r == 32'sd0)       && (cnt_r == CNT_W'(c));
              default:   wr_hit = 1'b0;
            endcase
          end
          if (wr_hit) begin
            win_next_s[r][c] = pix_if.pix_data;
          end else begin
            win_next_s[r][c] = win_r[r][c];
          end
        end
      end
    end else begin
      win_next_s = win_r;
    end
  end

  // State, counter, window storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      dir_r        <= 2'b00;
      loaded_r     <= 1'b0;
      pix_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
      shift_done_r <= 1'b0;
      err_cmd_r    <= 1'b0;
      win_valid_r  <= 1'b0;
      for (int r = 32'sd0; r < WIN; r++) begin
        for (int c = 32'sd0; c < WIN; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else begin
      state_r <= state_next_s;
      // Counter advances only on handshakes and wraps when the transfer ends.
      if (last_s) begin
        cnt_r <= '0;
      end else if (hs_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (shift_go_s) begin
        dir_r <= shift_direc;
      end
      loaded_r     <= loaded_next_s;
      pix_ready_r  <= busy_next_s;
      busy_r       <= busy_next_s;
      load_done_r  <= last_s && (state_r == ST_LOAD);
      shift_done_r <= last_s && (state_r == ST_FILL);
      err_cmd_r    <= err_s;
      win_valid_r  <= loaded_next_s & ~busy_next_s;
      win_r        <= win_next_s;
    end
  end

  assign pix_if.pix_ready = pix_ready_r;
  assign busy             = busy_r;
  assign load_done        = load_done_r;
  assign shift_done       = shift_done_r;
  assign err_cmd          = err_cmd_r;
  assign win_valid        = win_valid_r;

  for (genvar gr = 0; gr < WIN; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN; gc++) begin : g_col
      assign window[(gr*WIN+gc)*PIXEL_W +: PIXEL_W] = win_r[gr][gc];
    end
  end

endmodule

// File: tb/tb_window_buffer_param.sv
// -----------------------------------------------------------------------------
// tb_window_buffer_param
// Two instances: index 0 is WIN=3/PIXEL_W=8, index 1 is WIN=5/PIXEL_W=10.
// A 2-D array model per instance holds the expected window; loads write in
// raster order, shifts move the array and clear the vacated line, fills write
// the vacated line. Inputs change on the falling edge, outputs are read there.
// -----------------------------------------------------------------------------
module tb_window_buffer_param;

  localparam int B_RDY  = 5;
  localparam int B_BUSY = 4;
  localparam int B_LD   = 3;
  localparam int B_SD   = 2;
  localparam int B_ERR  = 1;
  localparam int B_WV   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [2];
  logic       sl_a  [2];
  logic       ss_a  [2];
  logic [1:0] dir_a [2];
  logic       pv_a  [2];
  int         pd_a  [2];

  logic         busy3, ld3, sd3, err3, wv3;
  logic         busy5, ld5, sd5, err5, wv5;
  logic [71:0]  window3;
  logic [249:0] window5;
  logic [5:0]   stat [2];

  window_buffer_param_if #(.PIXEL_W(8))  if3 ();
  window_buffer_param_if #(.PIXEL_W(10)) if5 ();

  assign if3.pix_valid = pv_a[0];
  assign if3.pix_data  = pd_a[0][7:0];
  assign if5.pix_valid = pv_a[1];
  assign if5.pix_data  = pd_a[1][9:0];

  assign stat[0] = {if3.pix_ready, busy3, ld3, sd3, err3, wv3};
  assign stat[1] = {if5.pix_ready, busy5, ld5, sd5, err5, wv5};

  window_buffer_param #(.PIXEL_W(8), .WIN(3)) dut3 (
    .clk(clk), .rst(rst_a[0]), .start_load(sl_a[0]), .start_shift(ss_a[0]),
    .shift_direc(dir_a[0]), .pix_if(if3.slave), .busy(busy3), .load_done(ld3),
    .shift_done(sd3), .err_cmd(err3), .win_valid(wv3), .window(window3)
  );

  window_buffer_param #(.PIXEL_W(10), .WIN(5)) dut5 (
    .clk(clk), .rst(rst_a[1]), .start_load(sl_a[1]), .start_shift(ss_a[1]),
    .shift_direc(dir_a[1]), .pix_if(if5.slave), .busy(busy5), .load_done(ld5),
    .shift_done(sd5), .err_cmd(err5), .win_valid(wv5), .window(window5)
  );

  int n_checks = 0;
  int n_errors = 0;
  int model [2][5][5];
  bit loaded_m [2];
  int vals_q[$];
  int pos_r[$];
  int pos_c[$];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int win_of(input int w);
    return (w == 0) ? 3 : 5;
  endfunction

  function automatic int get_elem(input int w, input int r, input int c);
    if (w == 0) return int'(window3[(r*3+c)*8 +: 8]);
    else        return int'(window5[(r*5+c)*10 +: 10]);
  endfunction

  task automatic check_window(input int w, input string tag);
    int nw = win_of(w);
    for (int r = 0; r < nw; r++)
      for (int c = 0; c < nw; c++)
        check_value($sformatf("%s%0d[%0d][%0d]", tag, w, r, c), get_elem(w, r, c), model[w][r][c]);
  endtask

  task automatic fill_random(input int w, input int n);
    int maxv = (w == 0) ? 255 : 1023;
    vals_q.delete();
    for (int k = 0; k < n; k++) vals_q.push_back(int'($urandom_range(maxv, 0)));
  endtask

  task automatic fill_seq(input int base, input int n);
    vals_q.delete();
    for (int k = 0; k < n; k++) vals_q.push_back(base + k);
  endtask

  task automatic set_raster(input int w);
    int nw = win_of(w);
    pos_r.delete(); pos_c.delete();
    for (int k = 0; k < nw*nw; k++) begin
      pos_r.push_back(k / nw);
      pos_c.push_back(k % nw);
    end
  endtask

  task automatic pulse_cmd(input int w, input bit l, input bit s, input bit [1:0] d);
    @(negedge clk);
    sl_a[w] = l; ss_a[w] = s; dir_a[w] = d;
    @(posedge clk);
    #1;
    sl_a[w] = 1'b0; ss_a[w] = 1'b0;
  endtask

  // Starts and ends on a falling edge; updates the model on every handshake.
  task automatic send_line(input int w, input int n, input bit gap, output int cycles, output int idle);
    int idx = 0;
    bit hs;
    cycles = 0; idle = 0;
    while (idx < n) begin
      if (cycles > 400) begin
        check_value("stream_timeout", idx, n);
        break;
      end
      pv_a[w] = gap ? ($urandom_range(1, 0) == 1) : 1'b1;
      pd_a[w] = vals_q[idx];
      hs = pv_a[w] && stat[w][B_RDY];
      if (!pv_a[w]) idle++;
      @(posedge clk);
      cycles++;
      if (hs) begin
        model[w][pos_r[idx]][pos_c[idx]] = vals_q[idx];
        idx++;
      end
      @(negedge clk);
    end
    pv_a[w] = 1'b0;
  endtask

  task automatic do_load(input int w, input bit gap, input bit both);
    int n = win_of(w) * win_of(w);
    int cyc, idl;
    set_raster(w);
    pulse_cmd(w, 1'b1, both, 2'b00);
    loaded_m[w] = 1'b0;
    @(negedge clk);
    check_value("load_err", stat[w][B_ERR], both);
    check_value("load_busy", stat[w][B_BUSY], 1);
    check_value("load_wv", stat[w][B_WV], 0);
    send_line(w, n, gap, cyc, idl);
    check_value("load_done", stat[w][B_LD], 1);
    check_value("load_done_busy", stat[w][B_BUSY], 0);
    check_value("load_latency", cyc, n + idl);
    loaded_m[w] = 1'b1;
    check_window(w, "load_win");
    @(negedge clk);
    check_value("load_done_pulse", stat[w][B_LD], 0);
    check_value("load_wv_after", stat[w][B_WV], loaded_m[w]);
  endtask

  task automatic model_shift(input int w, input bit [1:0] d);
    int nw = win_of(w);
    int tmp [5][5];
    for (int r = 0; r < nw; r++)
      for (int c = 0; c < nw; c++) begin
        tmp[r][c] = 0;
        case (d)
          2'b00: if (c < nw-1) tmp[r][c] = model[w][r][c+1];
          2'b01: if (c > 0)    tmp[r][c] = model[w][r][c-1];
          2'b10: if (r < nw-1) tmp[r][c] = model[w][r+1][c];
          default: if (r > 0)  tmp[r][c] = model[w][r-1][c];
        endcase
      end
    for (int r = 0; r < nw; r++)
      for (int c = 0; c < nw; c++) model[w][r][c] = tmp[r][c];
  endtask

  task automatic do_shift(input int w, input bit [1:0] d, input bit gap, input bit inject);
    int nw = win_of(w);
    int cyc, idl;
    model_shift(w, d);
    pos_r.delete(); pos_c.delete();
    for (int i = 0; i < nw; i++) begin
      case (d)
        2'b00:   begin pos_r.push_back(i);    pos_c.push_back(nw-1); end
        2'b01:   begin pos_r.push_back(i);    pos_c.push_back(0);    end
        2'b10:   begin pos_r.push_back(nw-1); pos_c.push_back(i);    end
        default: begin pos_r.push_back(0);    pos_c.push_back(i);    end
      endcase
    end
    pulse_cmd(w, 1'b0, 1'b1, d);
    @(negedge clk);
    check_value("shift_err", stat[w][B_ERR], 0);
    check_value("shift_busy", stat[w][B_BUSY], 1);
    check_value("shift_wv", stat[w][B_WV], 0);
    check_window(w, "shift_vacated");
    if (inject) begin
      sl_a[w] = 1'b1;
      @(posedge clk);
      #1 sl_a[w] = 1'b0;
      @(negedge clk);
      check_value("midfill_err", stat[w][B_ERR], 1);
      check_value("midfill_busy", stat[w][B_BUSY], 1);
      check_window(w, "midfill_win");
    end
    send_line(w, nw, gap, cyc, idl);
    check_value("shift_done", stat[w][B_SD], 1);
    check_value("shift_done_busy", stat[w][B_BUSY], 0);
    check_value("shift_latency", cyc, nw + idl);
    check_window(w, "shift_win");
    @(negedge clk);
    check_value("shift_done_pulse", stat[w][B_SD], 0);
    check_value("shift_wv_after", stat[w][B_WV], 1);
  endtask

  task automatic do_abort(input int w);
    int cyc, idl;
    fill_random(w, win_of(w) * win_of(w));
    set_raster(w);
    pulse_cmd(w, 1'b1, 1'b0, 2'b00);
    loaded_m[w] = 1'b0;
    @(negedge clk);
    send_line(w, 4, 1'b0, cyc, idl);
    rst_a[w] = 1'b1;
    @(posedge clk);
    #1 rst_a[w] = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) model[w][r][c] = 0;
    @(negedge clk);
    check_window(w, "abort_win");
    check_value("abort_stat", stat[w], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("abort_quiet", stat[w], 0);
    end
  endtask

  task automatic shift_unloaded(input int w);
    pulse_cmd(w, 1'b0, 1'b1, 2'b00);
    @(negedge clk);
    check_value("unloaded_shift_stat", stat[w], 6'b000010);
    check_window(w, "unloaded_win");
    @(negedge clk);
    check_value("unloaded_err_pulse", stat[w], 0);
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      rst_a[w] = 1'b1; sl_a[w] = 1'b0; ss_a[w] = 1'b0;
      dir_a[w] = 2'b00; pv_a[w] = 1'b0; pd_a[w] = 0;
      loaded_m[w] = 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) model[w][r][c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check_window(w, "rst_win");
      check_value("rst_stat", stat[w], 0);
    end

    // WIN=3, PIXEL_W=8
    shift_unloaded(0);
    fill_seq(0, 9);  do_load(0, 1'b0, 1'b0);
    fill_seq(20, 3); do_shift(0, 2'b00, 1'b0, 1'b0);
    fill_seq(30, 3); do_shift(0, 2'b10, 1'b0, 1'b0);
    fill_seq(40, 3); do_shift(0, 2'b11, 1'b0, 1'b0);
    fill_random(0, 3); do_shift(0, 2'b01, 1'b1, 1'b0);
    fill_seq(0, 9);  do_load(0, 1'b1, 1'b0);
    fill_random(0, 9); do_load(0, 1'b0, 1'b1);
    fill_random(0, 3); do_shift(0, 2'b00, 1'b0, 1'b1);
    do_abort(0);
    fill_random(0, 9); do_load(0, 1'b0, 1'b0);

    // WIN=5, PIXEL_W=10
    shift_unloaded(1);
    fill_random(1, 25);
    vals_q[0] = 1023; vals_q[24] = 1023; vals_q[12] = 0;
    do_load(1, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      fill_random(1, 5);
      vals_q[0] = 1023;
      do_shift(1, 2'(d), 1'(d % 2), 1'b0);
    end
    fill_random(1, 25); do_load(1, 1'b1, 1'b1);
    do_abort(1);
    fill_random(1, 25); do_load(1, 1'b0, 1'b0);
    fill_random(1, 5);  do_shift(1, 2'b10, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
